// File: rtl/br_issue_queue_pkg.sv
// Shared types for the branch issue queue: uop bundle, issue-queue uop and entry layout.
package br_issue_queue_pkg;

    localparam int PHYS_W  = 6;
    localparam int ROB_W   = 5;
    localparam int EPOCH_W = 2;

    typedef enum logic [1:0] {
        UOP_BR   = 2'd0,
        UOP_JAL  = 2'd1,
        UOP_JALR = 2'd2,
        UOP_RET  = 2'd3
    } uop_class_e;

    typedef struct packed {
        uop_class_e cls;
        logic       uses_rs1;
        logic       uses_rs2;
    } bundle_t;

    typedef struct packed {
        bundle_t             bundle;
        logic [ROB_W-1:0]    rob_idx;
        logic [PHYS_W-1:0]   prd_new;
        logic [EPOCH_W-1:0]  epoch;
        logic [PHYS_W-1:0]   prs1;
        logic [PHYS_W-1:0]   prs2;
    } rs_uop_t;

    typedef struct packed {
        rs_uop_t uop;
        logic    rdy1;
        logic    rdy2;
        logic    valid;
    } iq_entry_t;

endpackage

// File: rtl/br_issue_queue_if.sv
// Dispatch, wakeup, issue and flush signals of the branch issue queue.
interface br_issue_queue_if
    import br_issue_queue_pkg::*;
#(
    parameter int N_WAKE = 2
) ();

    logic                     enq_valid;
    logic                     enq_ready;
    rs_uop_t                  enq_uop;
    logic                     enq_rs1_rdy;
    logic                     enq_rs2_rdy;
    logic [N_WAKE-1:0]        wake_valid;
    logic [N_WAKE*PHYS_W-1:0] wake_preg;
    logic                     issue_valid;
    logic                     issue_ready;
    rs_uop_t                  issue_uop;
    logic                     flush;

    // Dispatch / writeback / BRU side.
    modport master (
        output enq_valid, enq_uop, enq_rs1_rdy, enq_rs2_rdy,
        output wake_valid, wake_preg, issue_ready, flush,
        input  enq_ready, issue_valid, issue_uop
    );

    // Queue side.
    modport slave (
        input  enq_valid, enq_uop, enq_rs1_rdy, enq_rs2_rdy,
        input  wake_valid, wake_preg, issue_ready, flush,
        output enq_ready, issue_valid, issue_uop
    );

endinterface

// File: rtl/br_issue_queue_wake_match.sv
// Compares one physical tag against all wakeup broadcast ports.
module br_issue_queue_wake_match
    import br_issue_queue_pkg::*;
#(
    parameter int N_WAKE = 2
) (
    input  logic [PHYS_W-1:0]        tag,
    input  logic [N_WAKE-1:0]        wake_valid,
    input  logic [N_WAKE*PHYS_W-1:0] wake_preg,
    output logic                     hit
);

    // Any valid broadcast carrying this tag is a hit.
    always_comb begin
        // NOTE: default assignment first so no path leaves hit unassigned (no latch).
        hit = 1'b0;
        for (int k = 0; k < N_WAKE; k++) begin
            if (wake_valid[k] && (wake_preg[k*PHYS_W +: PHYS_W] == tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/br_issue_queue.sv
// In-order issue queue for branch/jump uops between dispatch and the BRU.
module br_issue_queue
    import br_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int N_WAKE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    br_issue_queue_if.slave  bus
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    iq_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic [DEPTH-1:0]  hit1;
    logic [DEPTH-1:0]  hit2;
    logic              enq_hit1;
    logic              enq_hit2;
    logic              enq_rdy1;
    logic              enq_rdy2;
    logic              enq_fire;
    logic              deq_fire;

    // Per-entry source wakeup comparators.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_wake
        br_issue_queue_wake_match #(.N_WAKE(N_WAKE)) u_wm1 (
            .tag        (entries[i].uop.prs1),
            .wake_valid (bus.wake_valid),
            .wake_preg  (bus.wake_preg),
            .hit        (hit1[i])
        );
        br_issue_queue_wake_match #(.N_WAKE(N_WAKE)) u_wm2 (
            .tag        (entries[i].uop.prs2),
            .wake_valid (bus.wake_valid),
            .wake_preg  (bus.wake_preg),
            .hit        (hit2[i])
        );
    end

    // Same-cycle wakeup bypass for the uop being enqueued.
    br_issue_queue_wake_match #(.N_WAKE(N_WAKE)) u_enq_wm1 (
        .tag        (bus.enq_uop.prs1),
        .wake_valid (bus.wake_valid),
        .wake_preg  (bus.wake_preg),
        .hit        (enq_hit1)
    );
    br_issue_queue_wake_match #(.N_WAKE(N_WAKE)) u_enq_wm2 (
        .tag        (bus.enq_uop.prs2),
        .wake_valid (bus.wake_valid),
        .wake_preg  (bus.wake_preg),
        .hit        (enq_hit2)
    );

    assign enq_rdy1 = bus.enq_rs1_rdy || !bus.enq_uop.bundle.uses_rs1 || enq_hit1;
    assign enq_rdy2 = bus.enq_rs2_rdy || !bus.enq_uop.bundle.uses_rs2 || enq_hit2;

    // Full is judged from count alone; no enqueue-through-dequeue when full.
    assign bus.enq_ready   = (count != FULL_CNT) && !bus.flush;
    assign bus.issue_valid = entries[head].valid && entries[head].rdy1 && entries[head].rdy2;
    assign bus.issue_uop   = entries[head].uop;

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.issue_valid && bus.issue_ready;

    // Queue state: flush clears everything, otherwise wakeup, dequeue and enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset (it is tiny) so issue_uop reads all-zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].rdy1  <= 1'b0;
                entries[i].rdy2  <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking throughout; later writes to the same entry win (enqueue over wakeup).
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid && hit1[i]) entries[i].rdy1 <= 1'b1;
                if (entries[i].valid && hit2[i]) entries[i].rdy2 <= 1'b1;
            end
            if (deq_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (enq_fire) begin
                entries[tail] <= '{uop: bus.enq_uop, rdy1: enq_rdy1, rdy2: enq_rdy2, valid: 1'b1};
                tail          <= tail + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
